pool_window_reducer: RTL and testbench
======================================

// Module: pool_window_reducer
// PURPOSE
//  Streaming pooling reducer. Folds each window of POOL_SIZE consecutive input words into one min or max result.
//  Wraps one comparator instance; the comparator's registered output is the running accumulator.
//  Sits upstream of the pooling output buffer and takes words from the PE/activation stream.
//  Valid/ready handshake on both sides. Sustains 1 word/cycle except on the last word of a blocked window.
// PARAMETERS
//  DATA_WIDTH  16  width of data words (unsigned compare)
//  CNT_WIDTH   4   width of window-size config; max window = 2**CNT_WIDTH-1
// PORTS
//  CLK        in   1           clock
//  RESET      in   1           synchronous, active-high reset
//  POOL_SIZE  in   CNT_WIDTH   words per window; sampled on the first accepted word of each window
//  MODE_MAX   in   1           0=min, 1=max; sampled with POOL_SIZE
//  IN_DATA    in   DATA_WIDTH  input word
//  IN_VALID   in   1           input word valid
//  IN_READY   out  1           reducer can accept IN_DATA this cycle
//  OUT_DATA   out  DATA_WIDTH  reduced window result
//  OUT_VALID  out  1           OUT_DATA valid
//  OUT_READY  in   1           downstream accepts OUT_DATA
// BEHAVIOUR
//  - Accept: IN_VALID && IN_READY. Transfer out: OUT_VALID && OUT_READY.
//  - Reset: cnt=0, win_len=0, mode_q=0, pend=0, OUT_VALID=0, OUT_DATA=0, comparator output=0.
//    IN_READY is 1 in the cycle after reset.
//  - Window length: POOL_SIZE=0 is treated as 1. Latched into win_len, with MODE_MAX into mode_q, on the accept at cnt==0.
//    Changes to the config inputs mid-window are ignored.
//  - Max mode: both comparator operands and its result are bitwise-inverted. ~a<~b iff a>b, so the comparator itself is unchanged.
//  - Comparator operands (op = identity or ~ per mode_q):
//    - accept at cnt==0: (op(IN_DATA), op(IN_DATA)). Accumulator loads the first word.
//    - accept at cnt>0: (COMP_OUT, op(IN_DATA)).
//    - no accept: (COMP_OUT, COMP_OUT). Accumulator holds.
//  - Counter: cnt increments on each accept. On accepting the last word (cnt==win_len-1):
//    cnt wraps to 0 and pend is set for exactly one cycle.
//  - Result: when pend==1 the accumulator holds the final value.
//    OUT_DATA <= op(COMP_OUT) and OUT_VALID <= 1 at that edge; pend then clears.
//    Latency is 2 cycles from last-word accept to OUT_VALID.
//  - OUT_VALID clears on transfer unless a pend load happens on the same edge, in which case the load wins.
//  - IN_READY = (cnt_is_not_last) || (!pend && (!OUT_VALID || OUT_READY)).
//    A window can only complete when the output register is guaranteed free one cycle later.
//    Non-last words are never back-pressured.
//  - Back-to-back windows: the next window's first word may be accepted in the same cycle as pend.
//    The comparator is then fed (op(IN),op(IN)) and pend captures the previous result at the same edge.
//    Required: the pend load uses COMP_OUT before the edge.
//  - POOL_SIZE=1: every word is a last word; throughput 1 word per 2 cycles.
//  - OUT_DATA is stable while OUT_VALID && !OUT_READY.
//  - RESET mid-window: the partial window and any unread result are discarded; there is no flush output.
// STRUCTURE
//  - Sub-module: comparator (DATA_WIDTH), existing primitive; 1-cycle registered min; shares CLK and RESET.
//  - Local logic: cnt/win_len/mode_q registers, pend flag, operand muxes + inverters, output register.
//  - Shared package pool_pkg: MODE_MIN/MODE_MAX constants, default CNT_WIDTH.
//    No typedefs are needed beyond the width parameters.
// TESTING
//  1. POOL_SIZE=4, MIN, words 9,3,7,5 back-to-back, OUT_READY=1 -> OUT_DATA=3, OUT_VALID 2 cycles after word 5.
//  2. POOL_SIZE=4, MAX, 0x0001,0xFFFE,0x8000,0x0000 -> OUT_DATA=0xFFFE (unsigned compare).
//  3. POOL_SIZE=2 MIN, stream 4,8,6,2,1,9 with OUT_READY=1 -> outputs 4,2,1; IN_READY never drops.
//  4. POOL_SIZE=2, OUT_READY=0, two windows sent -> first result held.
//     IN_READY=0 on the last word of window 2 until OUT_READY=1; then output 2 follows with no loss.
//  5. POOL_SIZE=0 and POOL_SIZE=1, words 5,6 -> outputs 5 then 6; IN_READY toggles 1,0 pattern.
//  6. RESET asserted after 2 of 4 words, then 4 fresh words 8,6,4,2 MIN -> single output 2.
//     OUT_VALID=0 during and right after reset.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants for the pooling datapath: mode encodings and default widths.
package pool_pkg;
    localparam logic MODE_MIN       = 1'b0;
    localparam logic MODE_MAX       = 1'b1;
    localparam int   DATA_WIDTH_DEF = 16;
    localparam int   CNT_WIDTH_DEF  = 4;
endpackage

// File: rtl/pool_window_reducer_if.sv
// Stream + config bundle for the pooling reducer: input word stream, window
// config and the reduced-result output stream.
interface pool_window_reducer_if #(
    parameter int DATA_WIDTH = pool_pkg::DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = pool_pkg::CNT_WIDTH_DEF
);
    logic [CNT_WIDTH-1:0]  POOL_SIZE;
    logic                  MODE_MAX;
    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_VALID;
    logic                  OUT_READY;

    modport master (
        output POOL_SIZE, MODE_MAX, IN_DATA, IN_VALID, OUT_READY,
        input  IN_READY, OUT_DATA, OUT_VALID
    );

    modport slave (
        input  POOL_SIZE, MODE_MAX, IN_DATA, IN_VALID, OUT_READY,
        output IN_READY, OUT_DATA, OUT_VALID
    );
endinterface

// File: rtl/pool_window_reducer_comparator.sv
// Registered unsigned min of two operands; the pooling accumulator lives in
// this register.
module pool_window_reducer_comparator #(
    parameter int DATA_WIDTH = pool_pkg::DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_min
);
    always_ff @(posedge CLK) begin
        if (RESET) o_min <= '0;
        else       o_min <= (i_b < i_a) ? i_b : i_a;
    end
endmodule

// File: rtl/pool_window_reducer.sv
// Streaming min/max pooling: folds POOL_SIZE consecutive words into one result.
// Max mode runs the min comparator on inverted data (~a < ~b iff a > b).
module pool_window_reducer
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    pool_window_reducer_if.slave bus
);
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  r_win_len;
    logic                  r_mode;
    logic                  r_pend;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    logic [CNT_WIDTH-1:0]  w_cfg_len;
    logic [CNT_WIDTH-1:0]  w_len;
    logic                  w_first;
    logic                  w_last;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_mode;
    logic [DATA_WIDTH-1:0] w_in_op;
    logic [DATA_WIDTH-1:0] w_cmp_a;
    logic [DATA_WIDTH-1:0] w_cmp_b;
    logic [DATA_WIDTH-1:0] w_cmp_out;
    logic [DATA_WIDTH-1:0] w_result;

    // At cnt==0 the live config inputs decide window length and mode.
    assign w_first   = (r_cnt == '0);
    assign w_cfg_len = (bus.POOL_SIZE == '0) ? CNT_WIDTH'(1) : bus.POOL_SIZE;
    assign w_len     = w_first ? w_cfg_len : r_win_len;
    assign w_mode    = w_first ? bus.MODE_MAX : r_mode;
    assign w_last    = (r_cnt == w_len - CNT_WIDTH'(1));

    // Only a window-completing word waits for the output register to free up.
    assign w_in_ready = !w_last || (!r_pend && (!r_out_valid || bus.OUT_READY));
    assign w_accept   = bus.IN_VALID && w_in_ready;

    assign w_in_op  = (w_mode == MODE_MAX) ? ~bus.IN_DATA : bus.IN_DATA;
    assign w_result = (r_mode == MODE_MAX) ? ~w_cmp_out : w_cmp_out;

    always_comb begin
        w_cmp_a = w_cmp_out;
        w_cmp_b = w_cmp_out;
        if (w_accept) begin
            w_cmp_a = w_first ? w_in_op : w_cmp_out;
            w_cmp_b = w_in_op;
        end
    end

    pool_window_reducer_comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .CLK   (CLK),
        .RESET (RESET),
        .i_a   (w_cmp_a),
        .i_b   (w_cmp_b),
        .o_min (w_cmp_out)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt     <= '0;
            r_win_len <= '0;
            r_mode    <= MODE_MIN;
            r_pend    <= 1'b0;
        end else begin
            r_pend <= w_accept && w_last;
            if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + CNT_WIDTH'(1);
                if (w_first) begin
                    r_win_len <= w_cfg_len;
                    r_mode    <= bus.MODE_MAX;
                end
            end
        end
    end

    // The pend load reads r_mode before this edge, so a back-to-back window
    // that switches mode does not corrupt the previous result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (r_pend) begin
            r_out_data  <= w_result;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && bus.OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.IN_READY  = w_in_ready;
    assign bus.OUT_DATA  = r_out_data;
    assign bus.OUT_VALID = r_out_valid;
endmodule

// File: tb/tb_pool_window_reducer.sv
// Scoreboard bench for pool_window_reducer: directed cases plus randomized
// windows checked against a queue-based min/max reference model.
module tb_pool_window_reducer;
    localparam int DW = 16;
    localparam int CW = 4;

    logic CLK = 1'b0;
    logic RESET;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rdy_mode = 1;  // 0: stall, 1: always ready, 2: random

    pool_window_reducer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    pool_window_reducer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        case (rdy_mode)
            0:       bus.OUT_READY = 1'b0;
            1:       bus.OUT_READY = 1'b1;
            default: bus.OUT_READY = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: collect a window's words, reduce with plain min/max.
    logic [DW-1:0] win_q[$];
    logic [DW-1:0] exp_q[$];
    int            m_len;
    bit            m_max;
    bit            prev_v = 0, prev_r = 0;
    logic [DW-1:0] prev_d = '0;

    always @(negedge CLK) begin
        if (RESET) begin
            win_q.delete();
            exp_q.delete();
            prev_v = 0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", 32'(bus.OUT_VALID), 32'd1);
                chk("hold_data", 32'(bus.OUT_DATA), 32'(prev_d));
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (exp_q.size() == 0) chk("spurious_out", 32'(bus.OUT_DATA), 32'hFFFF_FFFF);
                else chk("out_data", 32'(bus.OUT_DATA), 32'(exp_q.pop_front()));
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                if (win_q.size() == 0) begin
                    m_len = (bus.POOL_SIZE == 0) ? 1 : int'(bus.POOL_SIZE);
                    m_max = bus.MODE_MAX;
                end
                win_q.push_back(bus.IN_DATA);
                if (win_q.size() == m_len) begin
                    logic [DW-1:0] r;
                    r = win_q[0];
                    foreach (win_q[i])
                        if (m_max ? (win_q[i] > r) : (win_q[i] < r)) r = win_q[i];
                    exp_q.push_back(r);
                    win_q.delete();
                end
            end
            prev_v = bus.OUT_VALID;
            prev_r = bus.OUT_READY;
            prev_d = bus.OUT_DATA;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [DW-1:0] w, input int ps, input bit md, output int waits);
        bus.IN_DATA   = w;
        bus.POOL_SIZE = CW'(ps);
        bus.MODE_MAX  = md;
        bus.IN_VALID  = 1'b1;
        waits = 0;
        forever begin
            @(negedge CLK);
            if (bus.IN_READY) begin
                @(posedge CLK); #1;
                break;
            end
            @(posedge CLK); #1;
            waits++;
            if (waits > 100) begin
                chk("send_timeout", 32'(waits), 32'd0);
                break;
            end
        end
        bus.IN_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Called right after the last word's accept: result shows one edge later.
    task automatic expect_out(input string name, input logic [DW-1:0] e);
        chk({name, "_early"}, 32'(bus.OUT_VALID), 32'd0);
        @(posedge CLK); #1;
        chk({name, "_valid"}, 32'(bus.OUT_VALID), 32'd1);
        chk({name, "_data"}, 32'(bus.OUT_DATA), 32'(e));
    endtask

    initial begin
        int w;
        logic [DW-1:0] s3 [6];
        s3 = '{16'd4, 16'd8, 16'd6, 16'd2, 16'd1, 16'd9};
        RESET = 1'b1;
        bus.IN_VALID = 1'b0;
        bus.IN_DATA = '0;
        bus.POOL_SIZE = '0;
        bus.MODE_MAX = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
        chk("rst_out_data", 32'(bus.OUT_DATA), 32'd0);
        RESET = 1'b0;
        chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);

        // 1: min of 9,3,7,5
        send(16'd9, 4, pool_pkg::MODE_MIN, w);
        send(16'd3, 4, pool_pkg::MODE_MIN, w);
        send(16'd7, 4, pool_pkg::MODE_MIN, w);
        send(16'd5, 4, pool_pkg::MODE_MIN, w);
        expect_out("t1", 16'd3);
        idle(3);

        // 2: unsigned max
        send(16'h0001, 4, pool_pkg::MODE_MAX, w);
        send(16'hFFFE, 4, pool_pkg::MODE_MAX, w);
        send(16'h8000, 4, pool_pkg::MODE_MAX, w);
        send(16'h0000, 4, pool_pkg::MODE_MAX, w);
        expect_out("t2", 16'hFFFE);
        idle(3);

        // 3: POOL_SIZE=2 streaming with no stalls
        for (int i = 0; i < 6; i++) begin
            send(s3[i], 2, pool_pkg::MODE_MIN, w);
            chk("t3_no_stall", 32'(w), 32'd0);
        end
        idle(4);

        // 4: output blocked; last word of window 2 must wait
        rdy_mode = 0;
        idle(2);
        send(16'd4, 2, pool_pkg::MODE_MIN, w);
        send(16'd8, 2, pool_pkg::MODE_MIN, w);
        send(16'd6, 2, pool_pkg::MODE_MIN, w);
        bus.IN_DATA = 16'd2;
        bus.IN_VALID = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk("t4_in_blocked", 32'(bus.IN_READY), 32'd0);
            chk("t4_held_data", 32'(bus.OUT_DATA), 32'd4);
            @(posedge CLK); #1;
        end
        rdy_mode = 1;
        send(16'd2, 2, pool_pkg::MODE_MIN, w);
        idle(4);

        // 5: POOL_SIZE 0 and 1 both mean single-word windows
        send(16'd5, 0, pool_pkg::MODE_MIN, w);
        send(16'd6, 0, pool_pkg::MODE_MIN, w);
        chk("t5_ps0_bubble", 32'(w), 32'd1);
        idle(3);
        send(16'd5, 1, pool_pkg::MODE_MAX, w);
        send(16'd6, 1, pool_pkg::MODE_MAX, w);
        chk("t5_ps1_bubble", 32'(w), 32'd1);
        idle(3);

        // 6: reset discards a partial window
        send(16'd10, 4, pool_pkg::MODE_MIN, w);
        send(16'd20, 4, pool_pkg::MODE_MIN, w);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("t6_rst_valid", 32'(bus.OUT_VALID), 32'd0);
        RESET = 1'b0;
        chk("t6_post_in_ready", 32'(bus.IN_READY), 32'd1);
        send(16'd8, 4, pool_pkg::MODE_MIN, w);
        chk("t6_post_valid", 32'(bus.OUT_VALID), 32'd0);
        send(16'd6, 4, pool_pkg::MODE_MIN, w);
        send(16'd4, 4, pool_pkg::MODE_MIN, w);
        send(16'd2, 4, pool_pkg::MODE_MIN, w);
        expect_out("t6", 16'd2);
        idle(3);

        // Random windows, random back-pressure, junk config mid-window
        rdy_mode = 2;
        for (int n = 0; n < 200; n++) begin
            int ps, len;
            bit md;
            ps  = $urandom_range(0, 15);
            md  = 1'($urandom_range(0, 1));
            len = (ps == 0) ? 1 : ps;
            for (int k = 0; k < len; k++) begin
                logic [DW-1:0] d;
                d = (n % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) idle(1);
                if (k == 0) send(d, ps, md, w);
                else        send(d, $urandom_range(0, 15), 1'($urandom_range(0, 1)), w);
            end
        end

        rdy_mode = 1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) idle(1);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
